// File: rtl/chain_dp_update.sv
// chain_dp_update: per-anchor chaining DP step, f_i = max(hdr_w, max_j sat(f_j + score(i,j))).
// Optional early termination on MAX_SKIP consecutive misses is built when CHAIN_DP_SKIP_EN is defined.
`default_nettype none

module chain_dp_update #(
    parameter int IDX_W    = 16,
    parameter int SC_W     = 32,
    parameter int MAX_SKIP = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hdr_valid,
    output logic             hdr_ready,
    input  logic [IDX_W-1:0] hdr_idx,
    input  logic [SC_W-1:0]  hdr_w,
    input  logic             hdr_nopred,
    input  logic             p_valid,
    output logic             p_ready,
    input  logic [IDX_W-1:0] p_idx,
    input  logic [SC_W-1:0]  p_score,
    input  logic [SC_W-1:0]  p_f,
    input  logic             p_last,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [IDX_W-1:0] o_idx,
    output logic [SC_W-1:0]  o_f,
    output logic [IDX_W-1:0] o_pred,
    output logic             o_has_pred
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] OUT   = 2'd2;
`ifdef CHAIN_DP_SKIP_EN
    localparam logic [1:0] DRAIN = 2'd3;
    localparam int SKIP_W = $clog2(MAX_SKIP + 1);
`endif

    localparam logic signed [SC_W-1:0] SC_MAX = {1'b0, {(SC_W-1){1'b1}}};
    localparam logic signed [SC_W-1:0] SC_MIN = {1'b1, {(SC_W-1){1'b0}}};

    if (MAX_SKIP < 1) begin : g_max_skip_check
        $error("MAX_SKIP must be at least 1");
    end

    logic [1:0]              state;
    logic [1:0]              next_state;
    logic signed [SC_W-1:0]  best_f;
    logic [IDX_W-1:0]        best_j;
    logic                    has;
    logic [IDX_W-1:0]        idx;
    logic signed [SC_W-1:0]  cand;
    logic signed [SC_W:0]    wide_sum;
    logic                    improve;
    logic                    hdr_fire;
    logic                    p_fire;
    logic                    o_fire;

    // One extra bit catches signed overflow; the sign of the wide sum picks the clamp direction.
    assign wide_sum = {p_f[SC_W-1], p_f} + {p_score[SC_W-1], p_score};
    always_comb begin
        cand = wide_sum[SC_W-1:0];
        if (wide_sum[SC_W] != wide_sum[SC_W-1]) begin
            cand = wide_sum[SC_W] ? SC_MIN : SC_MAX;
        end
    end

    assign improve  = cand > best_f;
    assign hdr_fire = hdr_valid && hdr_ready;
    assign p_fire   = p_valid && p_ready;
    assign o_fire   = o_valid && o_ready;

`ifdef CHAIN_DP_SKIP_EN
    logic [SKIP_W-1:0] skip_cnt;
    logic [SKIP_W-1:0] skip_next;
    logic              skip_hit;

    assign skip_next = (skip_cnt == SKIP_W'(MAX_SKIP)) ? skip_cnt : skip_cnt + 1'b1;
    assign skip_hit  = !improve && (skip_next == SKIP_W'(MAX_SKIP));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (hdr_fire) begin
                    next_state = hdr_nopred ? OUT : ACCUM;
                end
            end
            ACCUM: begin
                if (p_fire) begin
                    if (p_last) begin
                        next_state = OUT;
`ifdef CHAIN_DP_SKIP_EN
                    end else if (skip_hit) begin
                        next_state = DRAIN;
`endif
                    end
                end
            end
`ifdef CHAIN_DP_SKIP_EN
            DRAIN: begin
                if (p_fire && p_last) begin
                    next_state = OUT;
                end
            end
`endif
            OUT: begin
                if (o_fire) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        hdr_ready = 1'b0;
        p_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE:  hdr_ready = 1'b1;
            ACCUM: p_ready   = 1'b1;
`ifdef CHAIN_DP_SKIP_EN
            DRAIN: p_ready   = 1'b1;
`endif
            OUT:   o_valid   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_f   <= '0;
            best_j   <= '0;
            has      <= 1'b0;
            idx      <= '0;
`ifdef CHAIN_DP_SKIP_EN
            skip_cnt <= '0;
`endif
        end else if (hdr_fire) begin
            best_f   <= hdr_w;
            best_j   <= '0;
            has      <= 1'b0;
            idx      <= hdr_idx;
`ifdef CHAIN_DP_SKIP_EN
            skip_cnt <= '0;
`endif
        end else if (state == ACCUM && p_fire) begin
            // Strict compare: on a tie the earlier predecessor stays.
            if (improve) begin
                best_f   <= cand;
                best_j   <= p_idx;
                has      <= 1'b1;
`ifdef CHAIN_DP_SKIP_EN
                skip_cnt <= '0;
`endif
            end else begin
`ifdef CHAIN_DP_SKIP_EN
                skip_cnt <= skip_next;
`endif
            end
        end
    end

    assign o_idx      = idx;
    assign o_f        = best_f;
    assign o_pred     = best_j;
    assign o_has_pred = has;

endmodule

`default_nettype wire

// File: doc/chain_dp_update.md
CHAIN_DP_UPDATE -- requirements
Module: chain_dp_update

Interface
REQ-001 Parameter IDX_W, default 16, anchor index width.
REQ-002 Parameter SC_W, default 32, score width, two's-complement signed.
REQ-003 Parameter MAX_SKIP, default 25, consecutive non-improving predecessor limit (used only under CHAIN_DP_SKIP_EN).
REQ-004 clk  in  1  clock, rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 hdr_valid / hdr_ready  in / out  1 / 1  anchor header handshake.
REQ-007 hdr_idx  in  IDX_W  index i of the anchor being scored.
REQ-008 hdr_w  in  SC_W  initial score (anchor seed span); this is the f_i floor.
REQ-009 hdr_nopred  in  1  anchor has no predecessors; no beats follow.
REQ-010 p_valid / p_ready  in / out  1 / 1  predecessor beat handshake.
REQ-011 p_idx  in  IDX_W  predecessor index j.
REQ-012 p_score  in  SC_W  pairwise score(i,j) from the pairwise score stage (signed).
REQ-013 p_f  in  SC_W  chain score f_j of predecessor j.
REQ-014 p_last  in  1  final predecessor beat of the current anchor.
REQ-015 o_valid / o_ready  out / in  1 / 1  result handshake.
REQ-016 o_idx, o_f, o_pred, o_has_pred  out  IDX_W, SC_W, IDX_W, 1  anchor i, f_i, best j, 1 if some j beat hdr_w.

Function
REQ-017 FSM states: IDLE, ACCUM, DRAIN, OUT, one-hot or encoded.
REQ-018 hdr_ready=1 only in IDLE; p_ready=1 only in ACCUM and DRAIN; o_valid=1 only in OUT.
REQ-019 IDLE + header accepted: best_f<=hdr_w, best_j<=0, has<=0, skip_cnt<=0, idx<=hdr_idx; next is OUT if hdr_nopred=1, else ACCUM.
REQ-020 ACCUM beat accepted: cand=sat(p_f+p_score), SC_W-bit signed saturating add (clamp to max/min signed value).
REQ-021 If cand > best_f (strict, signed): best_f<=cand, best_j<=p_idx, has<=1, skip_cnt<=0; ties keep the earlier predecessor.
REQ-022 Non-improving beat: skip_cnt<=skip_cnt+1, saturating at MAX_SKIP.
REQ-023 Accepted beat with p_last=1: next state OUT regardless of update; its own candidate is still evaluated in ACCUM.
REQ-024 OUT: o_f=best_f, o_pred=best_j, o_has_pred=has, o_idx=idx held stable until o_ready; on o_valid&&o_ready go IDLE.
REQ-025 Latency: o_valid rises on the cycle after the p_last beat (or header with hdr_nopred) is accepted; throughput of 1 beat/cycle in ACCUM.
REQ-026 Header and o_ready in the same cycle: the header is not accepted until IDLE (one bubble cycle per anchor).
REQ-027 p_valid in IDLE/OUT is ignored (p_ready=0); hdr_valid outside IDLE is ignored.
REQ-028 Outputs o_f/o_pred/o_idx/o_has_pred are registers, not combinational from inputs.

Reset
REQ-029 Reset asserted: state<=IDLE, all datapath registers and outputs <=0, hdr_ready=1 after deassertion, p_ready=0, o_valid=0.
REQ-030 Reset mid-anchor (ACCUM/DRAIN/OUT) discards the partial result; no o_valid is produced for that anchor.

Configuration
REQ-031 Macro CHAIN_DP_SKIP_EN defined: when skip_cnt reaches MAX_SKIP in ACCUM, go to DRAIN; DRAIN accepts beats with no update until p_last, then OUT.
REQ-032 CHAIN_DP_SKIP_EN undefined: DRAIN state and skip_cnt are not built; every beat is evaluated.

Verification
REQ-033 hdr_w=10, nopred=1 -> o_valid next cycle, o_f=10, o_has_pred=0, o_pred=0.
REQ-034 hdr_w=10; beats (j=3,f=20,s=5),(j=7,f=30,s=-5,last) -> o_f=25, o_pred=3 (tie keeps earlier j).
REQ-035 Beat p_f=0x7FFFFFF0, p_score=0x100 -> o_f=0x7FFFFFFF (saturated), o_pred set.
REQ-036 o_ready held 0 for 5 cycles in OUT -> outputs stable, hdr_ready=0, no beat accepted.
REQ-037 With CHAIN_DP_SKIP_EN, MAX_SKIP=2: beats improve, miss, miss, then improving beat, last -> improving beat ignored (DRAIN), o_f from first beat.
REQ-038 Reset pulsed after two ACCUM beats -> o_valid never rises; next header produces a clean result.
